// File: rtl/pci_pkg.sv
// Shared PCI target definitions: bus command codes and controller states.
// Used by pci_target_ctrl and pci_addr_decode.
package pci_pkg;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        DATA = 2'd2,
        DISC = 2'd3
    } state_t;

endpackage

// File: rtl/pci_addr_decode.sv
// Address-phase hit detection: 64-byte window match plus memory read/write
// command check.
module pci_addr_decode
    import pci_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic [31:0] address,
    input  logic [3:0]  command,
    output logic        hit
);

    logic unused_low;

    assign unused_low = ^address[5:0];

    assign hit = (address[31:6] == BASE_ADDR[31:6]) &&
                 ((command == CMD_MEM_READ) || (command == CMD_MEM_WRITE));

endmodule

// File: rtl/pci_target_ctrl.sv
// PCI memory target controller: claims a BASE_ADDR window, bursts, disconnects
// at the window end. Define PCI_WAIT_STATE_EN to add one initial wait cycle.
module pci_target_ctrl
    import pci_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          WIN_WORDS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FRAME_N,
    input  logic        IRDY_N,
    input  logic [3:0]  CBE,
    input  logic [31:0] AD_IN,
    output logic        DEVSEL_N,
    output logic        TRDY_N,
    output logic        STOP_N,
    output logic        R_W,
    output logic [31:0] MEM_ADDR,
    output logic        MEM_WE,
    output logic        MEM_RE,
    output logic [3:0]  MEM_BE
);

    localparam int OFF_W = $clog2(WIN_WORDS);

`ifdef PCI_WAIT_STATE_EN
    localparam logic WAIT_EN = 1'b1;
`else
    localparam logic WAIT_EN = 1'b0;
`endif

    state_t      state, state_n;
    logic [31:0] addr_n;
    logic        rd, rd_n;
    logic        armed, armed_n;
    logic        wait_pend, wait_n;
    logic        hit;
    logic        abort;
    logic        last_word;

    pci_addr_decode #(
        .BASE_ADDR(BASE_ADDR)
    ) u_dec (
        .address(AD_IN),
        .command(CBE),
        .hit    (hit)
    );

    assign abort     = FRAME_N && IRDY_N;
    assign last_word = &MEM_ADDR[OFF_W+1:2];

    // armed drops after reset or a miss until the bus is seen idle again
    always_comb begin
        state_n  = state;
        addr_n   = MEM_ADDR;
        rd_n     = rd;
        armed_n  = armed;
        wait_n   = wait_pend;
        DEVSEL_N = 1'b1;
        TRDY_N   = 1'b1;
        STOP_N   = 1'b1;
        R_W      = 1'b0;
        MEM_WE   = 1'b0;
        MEM_RE   = 1'b0;
        MEM_BE   = 4'h0;
        unique case (state)
            IDLE: begin
                if (!armed) begin
                    armed_n = abort;
                end else if (!FRAME_N) begin
                    addr_n = {AD_IN[31:2], 2'b00};
                    rd_n   = (CBE == CMD_MEM_READ);
                    if (hit) begin
                        wait_n  = WAIT_EN;
                        state_n = (CBE == CMD_MEM_READ) ? TURN : DATA;
                    end else begin
                        armed_n = 1'b0;
                    end
                end
            end
            TURN: begin
                DEVSEL_N = 1'b0;
                R_W      = rd;
                state_n  = abort ? IDLE : DATA;
            end
            DATA: begin
                DEVSEL_N = 1'b0;
                R_W      = rd;
                if (!wait_pend) begin
                    TRDY_N = 1'b0;
                    MEM_RE = rd;
                    MEM_WE = !rd && !IRDY_N;
                    MEM_BE = ~CBE;
                end
                if (abort) begin
                    state_n = IDLE;
                end else if (wait_pend) begin
                    wait_n = 1'b0;
                end else if (!IRDY_N) begin
                    addr_n = MEM_ADDR + 32'd4;
                    if (FRAME_N)
                        state_n = IDLE;
                    else if (last_word)
                        state_n = DISC;
                end
            end
            DISC: begin
                DEVSEL_N = 1'b0;
                STOP_N   = 1'b0;
                R_W      = rd;
                if (FRAME_N)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            MEM_ADDR  <= 32'h0;
            rd        <= 1'b0;
            armed     <= 1'b0;
            wait_pend <= 1'b0;
        end else begin
            state     <= state_n;
            MEM_ADDR  <= addr_n;
            rd        <= rd_n;
            armed     <= armed_n;
            wait_pend <= wait_n;
        end
    end

endmodule

// File: tb/tb_pci_target_ctrl.sv
// Self-checking bench for pci_target_ctrl: transaction-level expectation
// model checked every cycle, plus literal address/count checks per scenario.
module tb_pci_target_ctrl;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          WIN  = 16;
`ifdef PCI_WAIT_STATE_EN
    localparam int W = 1;
`else
    localparam int W = 0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        FRAME_N = 1'b1;
    logic        IRDY_N = 1'b1;
    logic [3:0]  CBE = 4'h0;
    logic [31:0] AD_IN = 32'h0;
    logic        DEVSEL_N, TRDY_N, STOP_N, R_W, MEM_WE, MEM_RE;
    logic [31:0] MEM_ADDR;
    logic [3:0]  MEM_BE;

    pci_target_ctrl #(
        .BASE_ADDR(BASE),
        .WIN_WORDS(WIN)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .FRAME_N (FRAME_N),
        .IRDY_N  (IRDY_N),
        .CBE     (CBE),
        .AD_IN   (AD_IN),
        .DEVSEL_N(DEVSEL_N),
        .TRDY_N  (TRDY_N),
        .STOP_N  (STOP_N),
        .R_W     (R_W),
        .MEM_ADDR(MEM_ADDR),
        .MEM_WE  (MEM_WE),
        .MEM_RE  (MEM_RE),
        .MEM_BE  (MEM_BE)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic        e_devsel, e_trdy, e_stop, e_rw, e_we, e_re;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    bit          e_addr_chk;
    bit          chk_en = 0;

    logic [31:0] wr_log[$];
    logic [31:0] rd_log[$];
    int claim_cnt = 0;
    int pre_cnt = 0;
    int stop_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            check("devsel_n", {31'b0, DEVSEL_N}, {31'b0, e_devsel});
            check("trdy_n", {31'b0, TRDY_N}, {31'b0, e_trdy});
            check("stop_n", {31'b0, STOP_N}, {31'b0, e_stop});
            check("r_w", {31'b0, R_W}, {31'b0, e_rw});
            check("mem_we", {31'b0, MEM_WE}, {31'b0, e_we});
            check("mem_re", {31'b0, MEM_RE}, {31'b0, e_re});
            check("mem_be", {28'b0, MEM_BE}, {28'b0, e_be});
            if (e_addr_chk)
                check("mem_addr", MEM_ADDR, e_addr);
        end
    end

    always @(negedge CLK) begin
        if (!RST) begin
            if (MEM_WE) wr_log.push_back(MEM_ADDR);
            if (MEM_RE && !IRDY_N && !TRDY_N) rd_log.push_back(MEM_ADDR);
            if (!DEVSEL_N) claim_cnt++;
            if (!DEVSEL_N && TRDY_N && STOP_N) pre_cnt++;
            if (!STOP_N) stop_cnt++;
        end
    end

    task automatic e_idle();
        e_devsel = 1; e_trdy = 1; e_stop = 1; e_rw = 0;
        e_we = 0; e_re = 0; e_be = 4'h0; e_addr_chk = 0;
    endtask

    task automatic e_claim(input logic rw, input logic [31:0] a);
        e_devsel = 0; e_trdy = 1; e_stop = 1; e_rw = rw;
        e_we = 0; e_re = 0; e_be = 4'h0; e_addr_chk = 1; e_addr = a;
    endtask

    task automatic drive(input logic f, input logic i, input logic [3:0] c,
                         input logic [31:0] d);
        FRAME_N = f; IRDY_N = i; CBE = c; AD_IN = d;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_idle(input int n);
        repeat (n) begin
            drive(1, 1, 4'h0, 32'h0);
            e_idle();
            tick();
        end
    endtask

    task automatic clear_logs();
        wr_log.delete(); rd_log.delete();
        claim_cnt = 0; pre_cnt = 0; stop_cnt = 0;
    endtask

    task automatic txn(input logic [31:0] a, input logic [3:0] c,
                       input int beats, input logic [3:0] be,
                       input int stall_at, input int stall_n);
        logic [31:0] cur;
        bit hit, rd, last;
        int k, stalled, offs;
        hit = (a[31:6] == BASE[31:6]) && (c == 4'b0110 || c == 4'b0111);
        rd  = (c == 4'b0110);
        cur = {a[31:2], 2'b00};
        drive(0, 1, c, a); e_idle(); tick();
        if (!hit) begin
            for (int j = 0; j < beats; j++) begin
                drive(j == beats - 1, 0, ~be, j); e_idle(); tick();
            end
            bus_idle(2);
            return;
        end
        if (rd) begin
            drive(beats == 1, 0, ~be, 0); e_claim(1, cur); tick();
        end
        repeat (W) begin
            drive(beats == 1, 0, ~be, 0); e_claim(rd, cur); tick();
        end
        k = 0; stalled = 0;
        while (k < beats) begin
            last = (k == beats - 1);
            if (k == stall_at && stalled < stall_n) begin
                drive(0, 1, ~be, 32'hDEAD_0000);
                e_claim(rd, cur); e_trdy = 0; e_re = rd; e_be = be;
                stalled++;
                tick();
            end else begin
                drive(last, 0, ~be, k);
                e_claim(rd, cur); e_trdy = 0; e_re = rd; e_we = !rd; e_be = be;
                tick();
                offs = int'(((cur - BASE) >> 2) % WIN);
                cur += 4;
                k++;
                if (!last && offs == WIN - 1) begin
                    repeat (2) begin
                        drive(0, 0, ~be, 0); e_claim(rd, cur); e_stop = 0; tick();
                    end
                    drive(1, 0, ~be, 0); e_claim(rd, cur); e_stop = 0; tick();
                    k = beats;
                end
            end
        end
        bus_idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        e_idle();
        drive(1, 1, 4'h0, 32'h0);
        #1;
        check("rst0_devsel", {31'b0, DEVSEL_N}, 32'd1);
        check("rst0_trdy", {31'b0, TRDY_N}, 32'd1);
        check("rst0_stop", {31'b0, STOP_N}, 32'd1);
        check("rst0_addr", MEM_ADDR, 32'h0);
        chk_en = 1;
        tick(); tick();
        RST = 0;
        bus_idle(2);

        // single write
        clear_logs();
        txn(32'h0000_1000, 4'b0111, 1, 4'hF, -1, 0);
        check("t1_nwr", wr_log.size(), 1);
        check("t1_wr0", at(wr_log, 0), 32'h1000);
        check("t1_claim", claim_cnt, 1 + W);
        check("t1_pre", pre_cnt, W);

        // four-beat read
        clear_logs();
        txn(32'h0000_1010, 4'b0110, 4, 4'hF, -1, 0);
        check("t2_nrd", rd_log.size(), 4);
        check("t2_rd0", at(rd_log, 0), 32'h1010);
        check("t2_rd1", at(rd_log, 1), 32'h1014);
        check("t2_rd2", at(rd_log, 2), 32'h1018);
        check("t2_rd3", at(rd_log, 3), 32'h101C);
        check("t2_pre", pre_cnt, 1 + W);

        // burst write into the window end
        clear_logs();
        txn(32'h0000_1038, 4'b0111, 4, 4'h3, -1, 0);
        check("t3_nwr", wr_log.size(), 2);
        check("t3_wr0", at(wr_log, 0), 32'h1038);
        check("t3_wr1", at(wr_log, 1), 32'h103C);
        check("t3_stop", stop_cnt, 3);

        // misses: wrong window, wrong command
        clear_logs();
        txn(32'h0000_2000, 4'b0111, 2, 4'hF, -1, 0);
        txn(32'h0000_1000, 4'b0010, 2, 4'hF, -1, 0);
        check("t4_claim", claim_cnt, 0);
        check("t4_nwr", wr_log.size(), 0);

        // write with three wait cycles
        clear_logs();
        txn(32'h0000_1000, 4'b0111, 3, 4'hC, 1, 3);
        check("t5_nwr", wr_log.size(), 3);
        check("t5_wr2", at(wr_log, 2), 32'h1008);
        check("t5_claim", claim_cnt, 6 + W);

        // master abort in the data phase
        clear_logs();
        drive(0, 1, 4'b0110, 32'h0000_1020); e_idle(); tick();
        drive(0, 0, 4'h0, 32'h0); e_claim(1, 32'h1020); tick();
        repeat (W) begin
            drive(0, 0, 4'h0, 32'h0); e_claim(1, 32'h1020); tick();
        end
        drive(1, 1, 4'h0, 32'h0); e_claim(1, 32'h1020);
        e_trdy = 0; e_re = 1; e_be = 4'hF; tick();
        bus_idle(2);
        check("t6_nrd", rd_log.size(), 0);
        check("t6_claim", claim_cnt, 2 + W);

        // reset during a read burst
        drive(0, 1, 4'b0110, 32'h0000_1000); e_idle(); tick();
        drive(0, 0, 4'h0, 32'h0); e_claim(1, 32'h1000); tick();
        repeat (W) begin
            drive(0, 0, 4'h0, 32'h0); e_claim(1, 32'h1000); tick();
        end
        drive(0, 0, 4'h0, 32'h0); e_claim(1, 32'h1000);
        e_trdy = 0; e_re = 1; e_be = 4'hF; tick();
        e_claim(1, 32'h1004); e_trdy = 0; e_re = 1; e_be = 4'hF;
        #2;
        RST = 1;
        e_idle();
        #1;
        check("rst_devsel", {31'b0, DEVSEL_N}, 32'd1);
        check("rst_trdy", {31'b0, TRDY_N}, 32'd1);
        check("rst_stop", {31'b0, STOP_N}, 32'd1);
        check("rst_rw", {31'b0, R_W}, 32'd0);
        check("rst_addr", MEM_ADDR, 32'h0);
        check("rst_we", {31'b0, MEM_WE}, 32'd0);
        check("rst_re", {31'b0, MEM_RE}, 32'd0);
        check("rst_be", {28'b0, MEM_BE}, 32'd0);
        tick();
        RST = 0;
        clear_logs();
        repeat (2) begin
            drive(0, 0, 4'h0, 32'h0); e_idle(); tick();
        end
        drive(0, 1, 4'b0111, 32'h0000_1000); e_idle(); tick();
        drive(1, 0, 4'h0, 32'h0); e_idle(); tick();
        bus_idle(1);
        check("t7_noclaim", claim_cnt, 0);
        txn(32'h0000_1004, 4'b0111, 1, 4'hF, -1, 0);
        check("t7_nwr", wr_log.size(), 1);
        check("t7_wr0", at(wr_log, 0), 32'h1004);
        check("t7_pre", pre_cnt, W);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pci_target_ctrl.md
PCI_TARGET_CTRL -- requirements
Module: pci_target_ctrl

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_1000, the window base, 64-byte aligned.
REQ-002 The block SHALL have parameter WIN_WORDS, default 16, the window size in 32-bit words (power of 2).
REQ-003 CLK  in  1  single clock; all state changes on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 FRAME_N  in  1  initiator frame, active-low.
REQ-006 IRDY_N  in  1  initiator ready, active-low.
REQ-007 CBE  in  4  command in the address phase; byte enables in data phases (passed through).
REQ-008 AD_IN  in  32  bus address/data as seen by the target.
REQ-009 DEVSEL_N  out  1  device select, active-low.
REQ-010 TRDY_N  out  1  target ready, active-low.
REQ-011 STOP_N  out  1  target disconnect, active-low.
REQ-012 R_W  out  1  address-buffer direction: 1 = target drives AD_OUT (bus read); 0 = AD_IN routed to memory (bus write).
REQ-013 MEM_ADDR  out  32  current word byte address.
REQ-014 MEM_WE  out  1  memory write strobe.
REQ-015 MEM_RE  out  1  memory read enable.
REQ-016 MEM_BE  out  4  byte enables, equal to ~CBE during data phases, else 4'h0.

Function
REQ-017 States SHALL be IDLE, TURN, DATA, DISC.
REQ-018 IDLE: on an edge with FRAME_N=0, the block SHALL latch AD_IN into MEM_ADDR with bits [1:0] forced to 0, and latch CBE as the command.
REQ-019 A hit SHALL be AD_IN[31:6]==BASE_ADDR[31:6] and command 4'b0110 (memory read) or 4'b0111 (memory write); a miss or any other command SHALL stay in IDLE, with no outputs asserted, until FRAME_N=1 and IRDY_N=1.
REQ-020 A write hit SHALL go to DATA; a read hit SHALL go to TURN for one cycle, then DATA.
REQ-021 In TURN, DATA and DISC, DEVSEL_N SHALL be 0; R_W SHALL be 1 for a read and 0 for a write.
REQ-022 In DATA, TRDY_N SHALL be 0; a transfer occurs on each edge with IRDY_N=0 and TRDY_N=0.
REQ-023 MEM_WE SHALL be combinational: 1 when in DATA, write command, IRDY_N=0.
REQ-024 MEM_RE SHALL be 1 throughout DATA for a read.
REQ-025 On each transfer, MEM_ADDR SHALL increment by 4.
REQ-026 IRDY_N=1 in DATA SHALL be a wait state: no increment and no strobe.
REQ-027 A transfer with FRAME_N=1 is the last one; the next state SHALL be IDLE, with DEVSEL_N and TRDY_N deasserted and R_W=0 the following cycle.
REQ-028 A transfer to the last window word (offset WIN_WORDS-1) with FRAME_N=0 SHALL go to DISC.
REQ-029 DISC SHALL drive STOP_N=0 and TRDY_N=1, with no strobes and no address wrap, held until FRAME_N=1; the block SHALL then go to IDLE.
REQ-030 If FRAME_N and IRDY_N are both 1 in TURN or DATA (master abort), the block SHALL return to IDLE next cycle.

Reset
REQ-031 Asserting RST in any state SHALL immediately force IDLE with DEVSEL_N=1, TRDY_N=1, STOP_N=1, R_W=0, MEM_ADDR=0, MEM_WE=0, MEM_RE=0, MEM_BE=0.
REQ-032 A burst interrupted by reset SHALL NOT resume; after RST deasserts, the next transaction SHALL be accepted only after FRAME_N is seen high.

Configuration
REQ-033 With PCI_WAIT_STATE_EN defined, the block SHALL insert exactly one cycle (TRDY_N=1, DEVSEL_N=0, no strobes) before the first data phase of every transaction, after TURN for reads.
REQ-034 Without PCI_WAIT_STATE_EN, the first data phase SHALL begin as specified in REQ-020.

Structure
REQ-035 Shared package pci_pkg SHALL hold the command codes (CMD_MEM_READ=4'b0110, CMD_MEM_WRITE=4'b0111) and the state encoding.
REQ-036 Address/command hit logic SHALL be the sub-module pci_addr_decode (inputs address, command; output hit).
REQ-037 pci_target_ctrl SHALL drive the address buffer's R_W.

Verification
REQ-038 Single write, address 0x1000, CBE=0111, then data phase CBE=0000 with FRAME_N=1 and IRDY_N=0 -> DEVSEL_N and TRDY_N low one cycle after the address phase; one MEM_WE pulse at 0x1000 with MEM_BE=4'hF; IDLE next cycle.
REQ-039 Four-beat read at 0x1010 -> one TURN cycle with R_W=1; MEM_ADDR 0x1010, 0x1014, 0x1018, 0x101C; DEVSEL_N=1 after the last beat.
REQ-040 Burst write from 0x1038 with FRAME_N held low -> transfers at 0x1038 and 0x103C; then STOP_N=0, TRDY_N=1 until FRAME_N=1; no write at 0x1040.
REQ-041 Address 0x2000 or command 4'b0010 -> DEVSEL_N stays 1 for the whole transaction; no strobes.
REQ-042 IRDY_N=1 for 3 cycles mid-write -> MEM_ADDR held and MEM_WE=0 for those cycles.
REQ-043 RST pulsed during DATA of a read -> all outputs at reset values at once; no claim until FRAME_N is seen high; the build with PCI_WAIT_STATE_EN shows one extra TRDY_N=1 cycle per transaction.
